// File: rtl/portal_indication_serializer_pkg.sv
// Shared types and helpers for the indication portal.
// Used by portal_msg_fifo and portal_indication_serializer.
package portal_pkg;

  localparam int unsigned PORTAL_WORD_W = 32;

  typedef logic [PORTAL_WORD_W-1:0] portal_word_t;

  localparam portal_word_t PORTAL_INTR_NONE = 32'hFFFF_FFFF;

  // Message size in bits for a given word count (words * 32).
  function automatic logic [15:0] portal_size_bits(input logic [3:0] words);
    return {7'b0, words, 5'b0};
  endfunction

endpackage

// File: rtl/portal_indication_serializer_fifo.sv
// Whole-message FIFO (WORDS*32 bits x DEPTH) with registered full/empty flags.
// Enqueue while full and dequeue while empty are ignored.
module portal_msg_fifo
  import portal_pkg::*;
#(
  parameter int unsigned WORDS = 2,
  parameter int unsigned DEPTH = 2
) (
  input  logic                           CLK,
  input  logic                           RST_N,
  input  logic                           i_enq,
  input  logic [WORDS*PORTAL_WORD_W-1:0] i_data,
  input  logic                           i_deq,
  output logic [WORDS*PORTAL_WORD_W-1:0] o_data,
  output logic                           o_full,
  output logic                           o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WORDS*PORTAL_WORD_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]                  r_wr_ptr;
  logic [AW-1:0]                  r_rd_ptr;
  logic [AW:0]                    r_count;
  logic [AW:0]                    w_count_nxt;
  logic                           r_full;
  logic                           r_empty;
  logic                           w_do_enq;
  logic                           w_do_deq;

  assign w_do_enq = i_enq && !r_full;
  assign w_do_deq = i_deq && !r_empty;

  always_comb begin
    w_count_nxt = r_count;
    if (w_do_enq && !w_do_deq) begin
      w_count_nxt = r_count + 1'b1;
    end else if (w_do_deq && !w_do_enq) begin
      w_count_nxt = r_count - 1'b1;
    end
  end

  // Flags come from the next count so RDY is a clean register output.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_do_enq) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_deq) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == (AW+1)'(DEPTH));
      r_empty <= (w_count_nxt == '0);
    end
  end

  always_ff @(posedge CLK) begin
    if (w_do_enq) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_full  = r_full;
  assign o_empty = r_empty;

endmodule

// File: rtl/portal_indication_serializer.sv
// Indication-output portal: per-method message FIFOs serialised MS word first onto 32-bit channels.
// Optional interrupt mask register enabled by defining PORTAL_INTR_MASK_EN.
module portal_indication_serializer
  import portal_pkg::*;
#(
  parameter int unsigned                NUM_METHODS  = 2,
  parameter int unsigned                MAX_WORDS    = 2,
  parameter int unsigned                FIFO_DEPTH   = 2,
  parameter logic [NUM_METHODS*4-1:0]   METHOD_WORDS = {4'd1, 4'd1}
) (
  input  logic                                 CLK,
  input  logic                                 RST_N,
  input  logic [NUM_METHODS-1:0]               EN_method_enq,
  input  logic [NUM_METHODS*MAX_WORDS*32-1:0]  method_enq_v,
  output logic [NUM_METHODS-1:0]               RDY_method_enq,
  input  logic [15:0]                          messageSize_methodNumber,
  output logic [15:0]                          messageSize_size,
  output logic [NUM_METHODS*32-1:0]            indications_first,
  output logic [NUM_METHODS-1:0]               RDY_indications_first,
  input  logic [NUM_METHODS-1:0]               EN_indications_deq,
  output logic [NUM_METHODS-1:0]               RDY_indications_deq,
  output logic [NUM_METHODS-1:0]               indications_notEmpty,
  output logic                                 intr_status,
  output logic [31:0]                          intr_channel
`ifdef PORTAL_INTR_MASK_EN
  ,
  input  logic                                 EN_intr_mask_write,
  input  logic [NUM_METHODS-1:0]               intr_mask_v
`endif
);

  localparam int unsigned MSG_W = MAX_WORDS * PORTAL_WORD_W;
  localparam int unsigned WCW   = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;

  logic [NUM_METHODS-1:0] w_full;
  logic [NUM_METHODS-1:0] w_empty;
  logic [NUM_METHODS-1:0] w_ne;
  logic [NUM_METHODS-1:0] w_pop;
  logic [NUM_METHODS-1:0] w_mask;
  logic [NUM_METHODS-1:0] w_pend;

  assign w_ne                  = ~w_empty;
  assign RDY_method_enq        = ~w_full;
  assign RDY_indications_first = w_ne;
  assign RDY_indications_deq   = w_ne;
  assign indications_notEmpty  = w_ne;

  for (genvar m = 0; m < NUM_METHODS; m++) begin : g_ch
    localparam int unsigned W = 32'(METHOD_WORDS[m*4 +: 4]);

    logic [MSG_W-1:0] w_head;
    logic [WCW-1:0]   r_wc;
    portal_word_t     w_word;
    logic             w_last;

    portal_msg_fifo #(
      .WORDS (MAX_WORDS),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .i_enq   (EN_method_enq[m]),
      .i_data  (method_enq_v[m*MSG_W +: MSG_W]),
      .i_deq   (w_pop[m]),
      .o_data  (w_head),
      .o_full  (w_full[m]),
      .o_empty (w_empty[m])
    );

    assign w_last   = (32'(r_wc) == W - 1);
    assign w_pop[m] = EN_indications_deq[m] && w_ne[m] && w_last;

    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        r_wc <= '0;
      end else if (EN_indications_deq[m] && w_ne[m]) begin
        r_wc <= w_last ? '0 : r_wc + 1'b1;
      end
    end

    // Used words sit in the low W*32 bits; counter 0 selects the most significant of them.
    always_comb begin
      w_word = '0;
      for (int unsigned k = 0; k < MAX_WORDS; k++) begin
        if (32'(r_wc) + k == W - 1) begin
          w_word = w_head[k*PORTAL_WORD_W +: PORTAL_WORD_W];
        end
      end
    end

    assign indications_first[m*32 +: 32] = w_ne[m] ? w_word : '0;

    a_enq_when_full: assert property (@(posedge CLK) disable iff (!RST_N)
      !(EN_method_enq[m] && w_full[m]));
    a_deq_when_empty: assert property (@(posedge CLK) disable iff (!RST_N)
      !(EN_indications_deq[m] && w_empty[m]));
  end

`ifdef PORTAL_INTR_MASK_EN
  logic [NUM_METHODS-1:0] r_mask;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_mask <= '0;
    end else if (EN_intr_mask_write) begin
      r_mask <= intr_mask_v;
    end
  end

  assign w_mask = r_mask;
`else
  assign w_mask = '1;
`endif

  assign w_pend      = w_ne & w_mask;
  assign intr_status = |w_pend;

  always_comb begin
    intr_channel = PORTAL_INTR_NONE;
    for (int unsigned i = NUM_METHODS; i > 0; i--) begin
      if (w_pend[i-1]) begin
        intr_channel = 32'(i - 1);
      end
    end
  end

  always_comb begin
    messageSize_size = '0;
    for (int unsigned m = 0; m < NUM_METHODS; m++) begin
      if (messageSize_methodNumber == 16'(m)) begin
        messageSize_size = portal_size_bits(METHOD_WORDS[m*4 +: 4]);
      end
    end
  end

endmodule
